aes_cipher_core: RTL and testbench
==================================

Name: aes_cipher_core

Overview:
Iterative AES-128 encryption datapath directly downstream of key_expand. Loads a 128-bit plaintext as four 32-bit words after a start pulse, using the same loading protocol as key_expand. Waits for key_expand done, then runs AddRoundKey(0) plus 10 rounds, fetching round keys one word per cycle through key_expand's combinational read port. Streams the 128-bit ciphertext out as four 32-bit words.

Parameters:
NR, 10, number of cipher rounds; only 10 (AES-128) is supported, matching key_expand.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; the plaintext words follow on the next 4 cycles
data_in  in  32  plaintext word; word 0 first; bits [31:24] are row 0 of the column
key_ready  in  1  connected to key_expand done
round_key  in  32  connected to key_expand round_key; combinational response to round_key_num/r_index
round_key_num  out  4  round-key select, 0..10
r_index  out  2  word (column) select, 0..3
busy  out  1  high from the first LOAD cycle until the last OUT cycle
data_out  out  32  ciphertext word; valid only while out_valid
out_valid  out  1  high for exactly 4 consecutive cycles, words 0..3 in order

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE.
  - All outputs are 0: busy, out_valid, data_out, round_key_num, r_index.
  - The state register and round counter are cleared.
  - Reset asserted mid-operation aborts the operation; no partial output is produced.
- IDLE:
  - start=1 -> LOAD. busy is registered and rises on the cycle after start.
- LOAD (4 cycles):
  - Captures data_in into column k (k=0..3) on each cycle.
  - Then goes to WAIT_KEY.
- WAIT_KEY:
  - Holds until key_ready=1, then goes to ARK with round=0.
  - key_ready already high gives 0 extra cycles.
- ARK (4 cycles per round):
  - Drives round_key_num=round and r_index=j (j=0..3).
  - Each cycle: state column j ^= round_key.
  - After j=3:
    - round<NR -> SUB, with round+1.
    - round=NR -> OUT.
- SUB (1 cycle):
  - Applies SubBytes (16 aes_sbox instances), then ShiftRows (row r rotated left by r), then MixColumns (over GF(2^8), polynomial 0x11B).
  - MixColumns is skipped when round=NR.
  - Then goes to ARK.
- Key stall: in ARK or SUB with key_ready=0 (key being reloaded), the FSM holds its state with no state update and resumes when key_ready returns to 1.
- OUT (4 cycles):
  - out_valid=1 and data_out=column j, j=0..3.
  - busy deasserts together with out_valid; then IDLE.
- Latency:
  - From the ARK entry cycle to the first out_valid: 4 + 10×(1+4) = 54 cycles.
  - Minimum from the start pulse to the first out_valid: 1 + 4 + 54 = 59 cycles.
- start while busy=1 is ignored.
- start on the same cycle as the last OUT word is also ignored. IDLE must be reached before a new start.
- round_key_num and r_index hold their last value outside ARK.

Optional Feature:
AES_ROUND_TRACE_EN
- Defined:
  - Adds output dbg_round[3:0], dbg_state[127:0] and dbg_valid.
  - dbg_valid pulses for 1 cycle after the final ARK word of each round 0..10.
  - dbg_state carries the full post-AddRoundKey state, column 0 in [127:96].
  - dbg_round carries the round number of that state.
- Undefined: these ports and their registers do not exist; behaviour and latency are otherwise identical.

Decomposition:
- aes_pkg holds:
  - the FSM enum state_t (IDLE, LOAD, WAIT_KEY, ARK, SUB, OUT);
  - localparam NR=10;
  - the 256-entry S-box constant array;
  - functions xtime() and mix_column().
  - key_expand is later refactored to share the same S-box constant.
- One sub-module, aes_sbox: combinational 8-bit in, 8-bit out table lookup, instantiated 16 times.

Test Plan:
1. FIPS-197 App. B:
   - Stimulus: key 2b7e1516 28aed2a6 abf71588 09cf4f3c into key_expand; plaintext 3243f6a8 885a308d 313198a2 e0370734.
   - Response: data_out 3925841d 02dc09fb dc118597 196a0b32 on 4 consecutive out_valid cycles.
   - Timing: the first valid word is exactly 54 cycles after ARK entry.
2. FIPS-197 App. C.1:
   - Stimulus: key 00010203 04050607 08090a0b 0c0d0e0f; plaintext 00112233 44556677 8899aabb ccddeeff.
   - Response: 69c4e0d8 6a7b0430 d8cdb780 70b4c55a.
3. Key-late:
   - Stimulus: plaintext loaded while key_expand is still expanding (key_ready=0).
   - Response: busy=1 and out_valid=0 until key_ready rises; ciphertext identical to test 1.
4. Mid-run key drop:
   - Stimulus: drop key_ready for 7 cycles during round 5.
   - Response: output delayed by exactly 7 cycles; ciphertext unchanged.
5. Reset mid-round:
   - Stimulus: assert reset during round 3 for 1 cycle.
   - Response: next cycle has busy=0, out_valid=0, data_out=0; a subsequent App. B run completes correctly.
6. Back-to-back / start ignored:
   - Stimulus: pulse start during SUB of round 2.
   - Response: no reload; the original ciphertext is produced.
   - Stimulus: a second start after returning to IDLE.
   - Response: encrypts the new block correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the cipher datapath and, later, key_expand.
// Contents:
//   NR         number of cipher rounds (AES-128 only)
//   state_t    cipher FSM states
//   SBOX       forward S-box lookup table
//   xtime      multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
//   mix_column MixColumns applied to one 32-bit column (row 0 in [31:24])
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_KEY,
    ARK,
    SUB,
    OUT
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    // 2*a0 ^ 3*a1 ^ a2 ^ a3, rotated for each output row
    r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {r0, r1, r2, r3};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational table lookup.
// Ports:
//   value   8-bit byte to substitute
//   result  substituted byte
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] result
);

  assign result = SBOX[value];

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES-128 encryption datapath. Takes a plaintext block as four
// 32-bit words after a start pulse, waits for the key schedule, then runs
// AddRoundKey(0) plus NR rounds, fetching round keys one word per cycle from
// key_expand's combinational read port, and streams the ciphertext out as
// four 32-bit words.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           one-cycle pulse; plaintext words 0..3 follow on data_in
//   data_in         plaintext word, row 0 of the column in [31:24]
//   key_ready       key_expand done; low stalls ARK/SUB
//   round_key       round-key word selected by round_key_num/r_index
//   round_key_num   round-key select (0..10)
//   r_index         column select within the round key (0..3)
//   busy            high from first LOAD cycle to last OUT cycle
//   data_out        ciphertext word, valid while out_valid
//   out_valid       high for 4 consecutive cycles, words 0..3
//
// Build option AES_ROUND_TRACE_EN adds dbg_round/dbg_state/dbg_valid, which
// publish the post-AddRoundKey state of every round 0..10 for one cycle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start
// LOAD     | capturing plaintext column cnt from data_in
// WAIT_KEY | plaintext loaded, waiting for key_ready
// ARK      | column r_index ^= round_key for round round_key_num
// SUB      | SubBytes + ShiftRows (+ MixColumns unless last round)
// OUT      | presenting ciphertext column cnt on data_out
module aes_cipher_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [31:0]  data_in,
  input  logic         key_ready,
  input  logic [31:0]  round_key,
  output logic [3:0]   round_key_num,
  output logic [1:0]   r_index,
  output logic         busy,
  output logic [31:0]  data_out,
  output logic         out_valid
`ifdef AES_ROUND_TRACE_EN
  ,
  output logic [3:0]   dbg_round,
  output logic [127:0] dbg_state,
  output logic         dbg_valid
`endif
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  state_t      state;
  logic [3:0]  round;
  logic [1:0]  cnt;
  logic [1:0]  cnt_nxt;
  logic [31:0] col [4];
  logic [7:0]  sb_out [16];
  logic [31:0] sr_col [4];
  logic [31:0] sub_col [4];
  logic        last_round;

  assign cnt_nxt    = cnt + 2'd1;
  assign last_round = (round == LAST_ROUND);

  // SubBytes on every state byte; byte (row r, column c) sits in
  // col[c][31-8r -: 8].
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      aes_sbox u_sbox (
        .value  (col[c][31-8*r -: 8]),
        .result (sb_out[4*c+r])
      );
    end

    // ShiftRows: row r of column c takes row r of column (c+r) mod 4.
    assign sr_col[c] = {sb_out[4*((c+0)%4)+0],
                        sb_out[4*((c+1)%4)+1],
                        sb_out[4*((c+2)%4)+2],
                        sb_out[4*((c+3)%4)+3]};

    // round has already been advanced when SUB runs, so last_round here
    // means this SUB belongs to the final round.
    assign sub_col[c] = last_round ? sr_col[c] : mix_column(sr_col[c]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      round         <= '0;
      cnt           <= '0;
      busy          <= 1'b0;
      out_valid     <= 1'b0;
      data_out      <= '0;
      round_key_num <= '0;
      r_index       <= '0;
      for (int i = 0; i < 4; i++) col[i] <= '0;
`ifdef AES_ROUND_TRACE_EN
      dbg_round     <= '0;
      dbg_state     <= '0;
      dbg_valid     <= 1'b0;
`endif
    end else begin
`ifdef AES_ROUND_TRACE_EN
      dbg_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end

        LOAD: begin
          col[cnt] <= data_in;
          cnt      <= cnt_nxt;
          if (cnt == 2'd3) begin
            // Skip WAIT_KEY entirely when the schedule is already done.
            if (key_ready) begin
              state         <= ARK;
              round         <= '0;
              round_key_num <= '0;
              r_index       <= '0;
            end else begin
              state <= WAIT_KEY;
            end
          end
        end

        WAIT_KEY: begin
          if (key_ready) begin
            state         <= ARK;
            round         <= '0;
            round_key_num <= '0;
            r_index       <= '0;
          end
        end

        ARK: begin
          // round_key is meaningless while key_expand is reloading.
          if (key_ready) begin
            col[r_index] <= col[r_index] ^ round_key;
            if (r_index == 2'd3) begin
`ifdef AES_ROUND_TRACE_EN
              dbg_valid <= 1'b1;
              dbg_round <= round;
              dbg_state <= {col[0], col[1], col[2], col[3] ^ round_key};
`endif
              if (last_round) begin
                state     <= OUT;
                out_valid <= 1'b1;
                data_out  <= col[0];
                cnt       <= '0;
              end else begin
                state <= SUB;
                round <= round + 4'd1;
              end
            end else begin
              r_index <= r_index + 2'd1;
            end
          end
        end

        SUB: begin
          if (key_ready) begin
            for (int i = 0; i < 4; i++) col[i] <= sub_col[i];
            state         <= ARK;
            round_key_num <= round;
            r_index       <= '0;
          end
        end

        OUT: begin
          if (cnt == 2'd3) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            data_out  <= '0;
          end else begin
            cnt      <= cnt_nxt;
            data_out <= col[cnt_nxt];
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cipher_core.sv
module tb_aes_cipher_core;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [31:0]  data_in;
  logic         key_ready;
  logic [31:0]  round_key;
  logic [3:0]   round_key_num;
  logic [1:0]   r_index;
  logic         busy;
  logic [31:0]  data_out;
  logic         out_valid;
`ifdef AES_ROUND_TRACE_EN
  logic [3:0]   dbg_round;
  logic [127:0] dbg_state;
  logic         dbg_valid;
`endif

  aes_cipher_core dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .data_in       (data_in),
    .key_ready     (key_ready),
    .round_key     (round_key),
    .round_key_num (round_key_num),
    .r_index       (r_index),
    .busy          (busy),
    .data_out      (data_out),
    .out_valid     (out_valid)
`ifdef AES_ROUND_TRACE_EN
    ,
    .dbg_round     (dbg_round),
    .dbg_state     (dbg_state),
    .dbg_valid     (dbg_valid)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [7:0] TB_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Key schedule model standing in for key_expand; index is {round, column}.
  logic [31:0] rk [64];
  assign round_key = key_ready ? rk[{round_key_num, r_index}] : 32'hdeadbeef;

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {TB_SBOX[t[31:24]], TB_SBOX[t[23:16]], TB_SBOX[t[15:8]], TB_SBOX[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 64; i++) rk[i] = (i < 44) ? w[i] : 32'h0;
  endtask

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  localparam int M_NORM       = 0;
  localparam int M_LATE       = 1;
  localparam int M_DROP       = 2;
  localparam int M_RST        = 3;
  localparam int M_SUB_START  = 4;
  localparam int M_LAST_START = 5;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           mode;
    int           exp_first;  // cycle of first out_valid, start cycle = 0
  } vec_t;

  vec_t vecs [8];

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  task automatic set_vec(input int i, input logic [127:0] key, input logic [127:0] pt,
                         input logic [127:0] ct, input int mode, input int exp_first);
    vecs[i].key       = key;
    vecs[i].pt        = pt;
    vecs[i].ct        = ct;
    vecs[i].mode      = mode;
    vecs[i].exp_first = exp_first;
  endtask

  task automatic run_vec(input int vi);
    vec_t        v;
    int          first_k;
    int          last_k;
    int          n_valid;
    logic [31:0] got [4];
    logic        busy_last;
    logic        tail_ok;
    logic        late_ok;
    v         = vecs[vi];
    expand_key(v.key);
    key_ready = (v.mode == M_LATE) ? 1'b0 : 1'b1;
    first_k   = -1;
    last_k    = -1;
    n_valid   = 0;
    busy_last = 1'b0;
    tail_ok   = 1'b1;
    late_ok   = 1'b1;
    for (int i = 0; i < 4; i++) got[i] = '0;

    for (int k = 0; k <= 90; k++) begin
      @(negedge clk);
      if (out_valid) begin
        if (first_k < 0) first_k = k;
        if (n_valid < 4) got[n_valid] = data_out;
        n_valid++;
        last_k = k;
      end
      if (first_k >= 0 && k == first_k + 3) busy_last = busy;
      if (first_k >= 0 && (k == first_k + 4 || k == first_k + 5) && busy) tail_ok = 1'b0;
      if (v.mode == M_LATE && k >= 1 && k <= 20 && !(busy && !out_valid)) late_ok = 1'b0;
      if (v.mode == M_RST && k == 22)
        check($sformatf("v%0d_reset_outputs", vi),
              {busy, out_valid, data_out, round_key_num, r_index}, '0);

      start = (k == 0)
           || (v.mode == M_SUB_START && k == 14)
           || (v.mode == M_LAST_START && first_k >= 0 && k == first_k + 3);
      if (k >= 1 && k <= 4) data_in = v.pt[127-32*(k-1) -: 32];
      else if (v.mode == M_SUB_START && k >= 15 && k <= 18) data_in = 32'hffffffff;
      else data_in = 32'h0;
      if (v.mode == M_LATE && k == 20) key_ready = 1'b1;
      if (v.mode == M_DROP && k == 31) key_ready = 1'b0;
      if (v.mode == M_DROP && k == 38) key_ready = 1'b1;
      reset = (v.mode == M_RST && k == 21);
    end

    if (v.mode == M_RST) begin
      check_int($sformatf("v%0d_no_partial_output", vi), n_valid, 0);
    end else begin
      check_int($sformatf("v%0d_first_valid_cycle", vi), first_k, v.exp_first);
      check_int($sformatf("v%0d_valid_count", vi), n_valid, 4);
      check_int($sformatf("v%0d_valid_span", vi), last_k - first_k, 3);
      for (int i = 0; i < 4; i++)
        check($sformatf("v%0d_word%0d", vi, i), got[i], v.ct[127-32*i -: 32]);
      check($sformatf("v%0d_busy_tail", vi), {busy_last, tail_ok}, 2'b11);
      check($sformatf("v%0d_key_sel_hold", vi), {round_key_num, r_index}, {4'd10, 2'd3});
    end
    if (v.mode == M_LATE)
      check($sformatf("v%0d_wait_busy_no_valid", vi), late_ok, 1'b1);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    data_in   = 32'h0;
    key_ready = 1'b0;
    for (int i = 0; i < 64; i++) rk[i] = 32'h0;

    set_vec(0, KEY_B, PT_B, CT_B, M_NORM,       59);
    set_vec(1, KEY_C, PT_C, CT_C, M_NORM,       59);
    set_vec(2, KEY_B, PT_B, CT_B, M_LATE,       75);
    set_vec(3, KEY_B, PT_B, CT_B, M_DROP,       66);
    set_vec(4, KEY_B, PT_B, CT_B, M_RST,        -1);
    set_vec(5, KEY_B, PT_B, CT_B, M_NORM,       59);
    set_vec(6, KEY_B, PT_B, CT_B, M_SUB_START,  59);
    set_vec(7, KEY_C, PT_C, CT_C, M_LAST_START, 59);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy",          busy,          1'b0);
    check("reset_out_valid",     out_valid,     1'b0);
    check("reset_data_out",      data_out,      32'h0);
    check("reset_round_key_num", round_key_num, 4'h0);
    check("reset_r_index",       r_index,       2'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_reset", {busy, out_valid}, 2'b00);

    for (int vi = 0; vi < 8; vi++) run_vec(vi);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
